prescaled_counter: RTL and testbench

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

---
 rtl/counter_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 13 +
 rtl/prescaled_counter.sv | 130 +++++++++++++
 tb/tb_prescaled_counter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the prescaled counter.
//   mode_e    : counter operating modes, encoded to match the 2-bit mode port
//   SEG_TABLE : active-low 7-segment glyphs 0-F; bits [6:0] = g..a, bit 7 = dp (off)
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_HOLD = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,   // 0 1 2 3
        8'h99, 8'h92, 8'h82, 8'hF8,   // 4 5 6 7
        8'h80, 8'h90, 8'h88, 8'h83,   // 8 9 A b
        8'hC6, 8'hA1, 8'h86, 8'h8E    // C d E F
    };

endpackage

// File: rtl/seg7_decode.sv
// Single hex digit to active-low 7-segment decoder (decimal point kept dark).
//   i_nibble : 4-bit value to display
//   o_seg    : active-low segments, bit 7 = dp
module seg7_decode
    import counter_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/prescaled_counter.sv
// Modulo up/down/load counter advanced by a free-running clock prescaler,
// with a heartbeat output and a six-digit hex display decode of the count.
//   ADC_CLK_10 : clock, all state updates on its rising edge
//   RST        : synchronous active-high reset
//   en         : count/load enable
//   mode       : 00 up, 01 down, 10 hold, 11 load
//   load_val   : value taken in load mode (clamped to MODULO-1)
//   count      : registered count value
//   tick       : one-cycle prescaler strobe
//   tc         : one-cycle terminal-count pulse, coincident with the wrap
//   heartbeat  : toggles on every tick
//   hex        : six active-low 7-segment digits, digit k at hex[8k+7:8k]
module prescaled_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 10_000_000,
    parameter int MODULO    = 2 ** WIDTH,
    parameter int RESET_VAL = 1
) (
    input  logic             ADC_CLK_10,
    input  logic             RST,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc,
    output logic             heartbeat,
    output logic [47:0]      hex
);

    localparam int               PRE_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(DIV - 1);
    localparam logic [WIDTH-1:0] COUNT_MAX  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MODULO_W   = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] COUNT_RST  = WIDTH'(RESET_VAL);
    localparam int               NUM_DIGITS = (WIDTH + 3) / 4;

    logic [PRE_W-1:0] r_pre;
    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_tc;
    logic             r_hb;

    mode_e            w_mode;
    logic             w_tick_evt;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;

    assign w_mode = mode_e'(mode);

    // The edge that raises tick is also the edge on which up/down counting acts.
    // With DIV=1 the prescaler sits at 0 == DIV-1, so this is true every cycle.
    assign w_tick_evt = (r_pre == PRE_LAST);

    // Compare one bit wider so MODULO = 2^WIDTH never clamps.
    assign w_load_clamped = ({1'b0, load_val} >= MODULO_W) ? COUNT_MAX : load_val;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        if (en) begin
            case (w_mode)
                MODE_UP: begin
                    if (w_tick_evt) begin
                        if (r_count == COUNT_MAX) begin
                            w_count_nxt = '0;
                            w_tc_nxt    = 1'b1;
                        end else begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
                end
                MODE_DOWN: begin
                    if (w_tick_evt) begin
                        if (r_count == '0) begin
                            w_count_nxt = COUNT_MAX;
                            w_tc_nxt    = 1'b1;
                        end else begin
                            w_count_nxt = r_count - 1'b1;
                        end
                    end
                end
                MODE_LOAD: w_count_nxt = w_load_clamped;
                default:   w_count_nxt = r_count;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ADC_CLK_10) begin
        if (RST) begin
            r_pre   <= '0;
            r_count <= COUNT_RST;
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
            r_hb    <= 1'b0;
        end else begin
            // Prescaler free-runs regardless of en/mode so its phase is never disturbed.
            r_pre   <= w_tick_evt ? '0 : r_pre + 1'b1;
            r_tick  <= w_tick_evt;
            r_hb    <= r_hb ^ w_tick_evt;
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign count     = r_count;
    assign tick      = r_tick;
    assign tc        = r_tc;
    assign heartbeat = r_hb;

    // Zero-extend so a partial top nibble decodes with its upper bits cleared.
    logic [23:0] w_nibbles;
    logic [7:0]  w_seg [6];

    assign w_nibbles = 24'(r_count);

    for (genvar k = 0; k < 6; k++) begin : g_digit
        seg7_decode u_dec (
            .i_nibble (w_nibbles[4*k +: 4]),
            .o_seg    (w_seg[k])
        );
        assign hex[8*k +: 8] = (k < NUM_DIGITS) ? w_seg[k] : 8'hFF;
    end

endmodule

// File: tb/tb_prescaled_counter.sv
// Testbench for prescaled_counter.
//   u_dut    : WIDTH=8, DIV=4, MODULO=10, RESET_VAL=1 -- table-driven, per-cycle scoreboard
//   u_dut_d1 : WIDTH=8, DIV=1 -- tick every cycle, hex of 8'h3A
//   u_dut_w6 : WIDTH=6, DIV=1, RESET_VAL=5 -- partial-nibble zero fill, blank digits, wrap
module tb_prescaled_counter;

    localparam int DIV = 4;
    localparam int MOD = 10;
    localparam int RV  = 1;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // main instance
    logic        rst0, en0;
    logic [1:0]  mode0;
    logic [7:0]  load0;
    logic [7:0]  count0;
    logic        tick0, tc0, hb0;
    logic [47:0] hex0;

    prescaled_counter #(.WIDTH(8), .DIV(DIV), .MODULO(MOD), .RESET_VAL(RV)) u_dut (
        .ADC_CLK_10 (clk),
        .RST        (rst0),
        .en         (en0),
        .mode       (mode0),
        .load_val   (load0),
        .count      (count0),
        .tick       (tick0),
        .tc         (tc0),
        .heartbeat  (hb0),
        .hex        (hex0)
    );

    // DIV=1 instance
    logic        rst1, en1;
    logic [1:0]  mode1;
    logic [7:0]  load1;
    logic [7:0]  count1;
    logic        tick1, tc1, hb1;
    logic [47:0] hex1;

    prescaled_counter #(.WIDTH(8), .DIV(1), .MODULO(256), .RESET_VAL(1)) u_dut_d1 (
        .ADC_CLK_10 (clk),
        .RST        (rst1),
        .en         (en1),
        .mode       (mode1),
        .load_val   (load1),
        .count      (count1),
        .tick       (tick1),
        .tc         (tc1),
        .heartbeat  (hb1),
        .hex        (hex1)
    );

    // 6-bit instance
    logic        rst2, en2;
    logic [1:0]  mode2;
    logic [5:0]  load2;
    logic [5:0]  count2;
    logic        tick2, tc2, hb2;
    logic [47:0] hex2;

    prescaled_counter #(.WIDTH(6), .DIV(1), .MODULO(64), .RESET_VAL(5)) u_dut_w6 (
        .ADC_CLK_10 (clk),
        .RST        (rst2),
        .en         (en2),
        .mode       (mode2),
        .load_val   (load2),
        .count      (count2),
        .tick       (tick2),
        .tc         (tc2),
        .heartbeat  (hb2),
        .hex        (hex2)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] glyph(input int n);
        case (n & 15)
            0: glyph = 8'hC0;  1: glyph = 8'hF9;  2: glyph = 8'hA4;  3: glyph = 8'hB0;
            4: glyph = 8'h99;  5: glyph = 8'h92;  6: glyph = 8'h82;  7: glyph = 8'hF8;
            8: glyph = 8'h80;  9: glyph = 8'h90; 10: glyph = 8'h88; 11: glyph = 8'h83;
           12: glyph = 8'hC6; 13: glyph = 8'hA1; 14: glyph = 8'h86; default: glyph = 8'h8E;
        endcase
    endfunction

    // Scoreboard for the main instance
    typedef struct {
        int count;
        bit tick;
        bit tc;
        bit hb;
    } exp_t;

    exp_t exp_q[$];

    int m_pre, m_count;
    bit m_tick, m_tc, m_hb;
    int seg_ticks, seg_tcs, seg_hb_toggles;

    task automatic step();
        exp_t e;
        bit   evt;
        logic prev_hb;
        if (rst0) begin
            m_pre = 0; m_tick = 0; m_tc = 0; m_hb = 0; m_count = RV;
        end else begin
            evt    = (m_pre == DIV - 1);
            m_pre  = (m_pre + 1) % DIV;
            m_tick = evt;
            m_tc   = 0;
            if (evt) m_hb = !m_hb;
            if (en0) begin
                case (mode0)
                    2'b00: if (evt) begin
                        m_count = (m_count + 1) % MOD;
                        m_tc    = (m_count == 0);
                    end
                    2'b01: if (evt) begin
                        m_tc    = (m_count == 0);
                        m_count = (m_count + MOD - 1) % MOD;
                    end
                    2'b11: m_count = (int'(load0) >= MOD) ? MOD - 1 : int'(load0);
                    default: ;
                endcase
            end
        end
        e.count = m_count; e.tick = m_tick; e.tc = m_tc; e.hb = m_hb;
        exp_q.push_back(e);
        prev_hb = hb0;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("count", 64'(count0), 64'(e.count));
        check("tick", 64'(tick0), 64'(e.tick));
        check("tc", 64'(tc0), 64'(e.tc));
        check("heartbeat", 64'(hb0), 64'(e.hb));
        check("hex", 64'(hex0), {16'h0, 32'hFFFF_FFFF, glyph(e.count >> 4), glyph(e.count)});
        if (tick0 === 1'b1) seg_ticks++;
        if (tc0 === 1'b1) seg_tcs++;
        if (hb0 !== prev_hb) seg_hb_toggles++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Segment table: inputs held for ncyc edges, then hand-derived end state checked.
    typedef struct {
        bit   rst;
        bit   en;
        logic [1:0] mode;
        int   load_val;
        int   ncyc;
        int   exp_count;
        int   exp_ticks;
        int   exp_tcs;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_hb1;

        rst0 = 1; en0 = 0; mode0 = 2'b00; load0 = 0;
        rst1 = 1; en1 = 0; mode1 = 2'b00; load1 = 0;
        rst2 = 1; en2 = 0; mode2 = 2'b00; load2 = 0;

        //          rst en mode   load ncyc cnt tks tcs
        tbl[0]  = '{1, 0, 2'b00,   0,   2,  1,  0, 0};  // reset
        tbl[1]  = '{0, 1, 2'b00,   0,  40,  1, 10, 1};  // up 40 cycles, one wrap
        tbl[2]  = '{0, 1, 2'b10,   0,   6,  1,  1, 0};  // hold
        tbl[3]  = '{0, 0, 2'b00,   0,   5,  1,  1, 0};  // en=0
        tbl[4]  = '{0, 1, 2'b11,   0,   1,  0,  1, 0};  // load 0 on a tick edge
        tbl[5]  = '{0, 1, 2'b01,   0,   4,  9,  1, 1};  // down wrap 0 -> 9
        tbl[6]  = '{0, 1, 2'b01,   0,   4,  8,  1, 0};  // down 9 -> 8, no tc
        tbl[7]  = '{0, 1, 2'b11,   7,   1,  7,  0, 0};  // load 7
        tbl[8]  = '{0, 1, 2'b11, 200,   1,  9,  0, 0};  // load clamps
        tbl[9]  = '{0, 1, 2'b11,  10,   1,  9,  0, 0};  // clamp boundary
        tbl[10] = '{0, 1, 2'b00,   0,   1,  0,  1, 1};  // up wrap 9 -> 0
        tbl[11] = '{0, 1, 2'b11,   9,   3,  9,  0, 0};  // park at 9 just before tick
        tbl[12] = '{1, 1, 2'b00,   0,   1,  1,  0, 0};  // reset on tick edge
        tbl[13] = '{0, 1, 2'b00,   0,   4,  2,  1, 0};  // first tick 4 edges later
        tbl[14] = '{0, 1, 2'b00,   0,   2,  2,  0, 0};  // mid-count
        tbl[15] = '{1, 1, 2'b00,   0,   1,  1,  0, 0};  // reset discards pending tick
        tbl[16] = '{0, 1, 2'b00,   0,   3,  1,  0, 0};
        tbl[17] = '{0, 1, 2'b00,   0,   1,  2,  1, 0};

        for (int i = 0; i < 18; i++) begin
            rst0  = tbl[i].rst;
            en0   = tbl[i].en;
            mode0 = tbl[i].mode;
            load0 = 8'(tbl[i].load_val);
            seg_ticks = 0; seg_tcs = 0; seg_hb_toggles = 0;
            for (int c = 0; c < tbl[i].ncyc; c++) step();
            check($sformatf("seg%0d end count", i), 64'(count0), 64'(tbl[i].exp_count));
            check($sformatf("seg%0d tick count", i), 64'(seg_ticks), 64'(tbl[i].exp_ticks));
            check($sformatf("seg%0d tc count", i), 64'(seg_tcs), 64'(tbl[i].exp_tcs));
            if (!tbl[i].rst)
                check($sformatf("seg%0d hb toggles", i), 64'(seg_hb_toggles), 64'(tbl[i].exp_ticks));
        end
        en0 = 0;

        // DIV=1: reset, load 8'h3A, then hold with en=0
        cyc();
        check("d1 reset count", 64'(count1), 64'd1);
        check("d1 reset tick", 64'(tick1), 64'd0);
        check("d1 reset hb", 64'(hb1), 64'd0);
        rst1 = 0; en1 = 1; mode1 = 2'b11; load1 = 8'h3A;
        cyc();
        check("d1 load count", 64'(count1), 64'h3A);
        check("d1 first tick", 64'(tick1), 64'd1);
        check("d1 load tc", 64'(tc1), 64'd0);
        exp_hb1 = 1;
        check("d1 hb", 64'(hb1), 64'(exp_hb1));
        en1 = 0; mode1 = 2'b00;
        for (int c = 0; c < 5; c++) begin
            cyc();
            exp_hb1 = !exp_hb1;
            check("d1 tick every cycle", 64'(tick1), 64'd1);
            check("d1 count held", 64'(count1), 64'h3A);
            check("d1 hb toggle", 64'(hb1), 64'(exp_hb1));
            check("d1 hex 3A", 64'(hex1), {16'h0, 32'hFFFF_FFFF, 8'hB0, 8'h88});
        end
        en1 = 1;
        cyc();
        cyc();
        check("d1 up count", 64'(count1), 64'h3C);
        check("d1 up hex", 64'(hex1), {16'h0, 32'hFFFF_FFFF, 8'hB0, 8'hC6});

        // WIDTH=6: zero-filled top nibble, blank upper digits, wrap at 63
        cyc();
        check("w6 reset count", 64'(count2), 64'd5);
        check("w6 reset hex", 64'(hex2), {16'h0, 32'hFFFF_FFFF, 8'hC0, 8'h92});
        rst2 = 0; en2 = 1; mode2 = 2'b11; load2 = 6'h3F;
        cyc();
        check("w6 load count", 64'(count2), 64'h3F);
        check("w6 load hex", 64'(hex2), {16'h0, 32'hFFFF_FFFF, 8'hB0, 8'h8E});
        check("w6 load tc", 64'(tc2), 64'd0);
        mode2 = 2'b00;
        cyc();
        check("w6 wrap count", 64'(count2), 64'd0);
        check("w6 wrap tc", 64'(tc2), 64'd1);
        check("w6 wrap hex", 64'(hex2), {16'h0, 32'hFFFF_FFFF, 8'hC0, 8'hC0});
        cyc();
        check("w6 after wrap count", 64'(count2), 64'd1);
        check("w6 after wrap tc", 64'(tc2), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
